// File: rtl/imem_port_arbiter.sv
// ============================================================================
// Module   : imem_port_arbiter
// Shares the single-ported instruction memory between IF fetch reads and
// boot-time loader writes; sequences each access and drives the IF freeze.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_port_arbiter #(
  parameter int MEM_LAT  = 2,
  parameter int LD_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_flush_i,
  output logic        fetch_rvalid_o,
  output logic [31:0] fetch_rdata_o,
  output logic        freeze_o,
  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_wdata_i,
  output logic        ld_done_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STREAK_W = $clog2(LD_BURST + 1);
  localparam logic [CNT_W-1:0]    C_LAT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [STREAK_W-1:0] C_BURST    = STREAK_W'(LD_BURST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [STREAK_W-1:0] ld_streak_q, ld_streak_d;
  logic                flush_pend_q, flush_pend_d;
  logic                ld_win_w;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^{fetch_addr_i[1:0], ld_addr_i[1:0]};

  // The loader may only keep winning against a waiting fetch for LD_BURST grants.
  assign ld_win_w = ld_req_i & (~fetch_req_i | (ld_streak_q < C_BURST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      ld_streak_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      ld_streak_q  <= ld_streak_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    ld_streak_d    = ld_streak_q;
    flush_pend_d   = flush_pend_q;
    fetch_rvalid_o = 1'b0;
    fetch_rdata_o  = '0;
    ld_done_o      = 1'b0;
    mem_en_o       = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;

    case (state_q)
      S_IDLE: begin
        if (ld_win_w) begin
          mem_en_o    = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {ld_addr_i[31:2], 2'b00};
          mem_wdata_o = ld_wdata_i;
          state_d     = S_WR;
          lat_cnt_d   = C_LAT_INIT;
          if (fetch_req_i && (ld_streak_q < C_BURST)) begin
            ld_streak_d = ld_streak_q + 1'b1;
          end
        end else if (fetch_req_i) begin
          mem_en_o    = 1'b1;
          mem_addr_o  = {fetch_addr_i[31:2], 2'b00};
          state_d     = S_RD;
          lat_cnt_d   = C_LAT_INIT;
          ld_streak_d = '0;
        end
      end
      S_RD: begin
        if (lat_cnt_q == '0) begin
          if (!(flush_pend_q || fetch_flush_i)) begin
            fetch_rvalid_o = 1'b1;
            fetch_rdata_o  = mem_rdata_i;
          end
          flush_pend_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
          if (fetch_flush_i) begin
            flush_pend_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (lat_cnt_q == '0) begin
          ld_done_o = 1'b1;
          state_d   = S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!fetch_req_i) begin
      ld_streak_d = '0;
    end

    // Outputs are combinational, so hold them quiet while reset is asserted.
    if (rst) begin
      fetch_rvalid_o = 1'b0;
      fetch_rdata_o  = '0;
      ld_done_o      = 1'b0;
      mem_en_o       = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
    end
  end

  assign freeze_o = fetch_req_i & ~fetch_rvalid_o;

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ============================================================================
// Module   : tb_imem_port_arbiter
// Directed self-checking bench for imem_port_arbiter (MEM_LAT=2, LD_BURST=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_port_arbiter;

  localparam int MEM_LAT  = 2;
  localparam int LD_BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_flush, fetch_rvalid, freeze;
  logic [31:0] fetch_addr, fetch_rdata;
  logic        ld_req, ld_done;
  logic [31:0] ld_addr, ld_wdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  imem_port_arbiter #(.MEM_LAT(MEM_LAT), .LD_BURST(LD_BURST)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req_i    (fetch_req),
    .fetch_addr_i   (fetch_addr),
    .fetch_flush_i  (fetch_flush),
    .fetch_rvalid_o (fetch_rvalid),
    .fetch_rdata_o  (fetch_rdata),
    .freeze_o       (freeze),
    .ld_req_i       (ld_req),
    .ld_addr_i      (ld_addr),
    .ld_wdata_i     (ld_wdata),
    .ld_done_o      (ld_done),
    .mem_en_o       (mem_en),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data is only valid exactly MEM_LAT cycles after mem_en.
  logic [31:0] rd_addr_q = '0;
  int          rd_cnt    = 0;
  always @(posedge clk) begin
    if (mem_en && !mem_we) begin
      rd_addr_q <= mem_addr;
      rd_cnt    <= MEM_LAT;
    end else if (rd_cnt > 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end
  assign mem_rdata = (rd_cnt == 1) ? {16'hC0DE, rd_addr_q[15:0]} : 32'hBAD0BAD0;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h8; fetch_flush = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hFFFF0000;
    @(posedge clk); @(posedge clk); #1;
    mid;
    checks++;
    if ({fetch_rvalid, ld_done, mem_en, mem_we} !== 4'b0000 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || fetch_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: rv=%b done=%b en=%b we=%b addr=%h wd=%h rd=%h want all 0",
               fetch_rvalid, ld_done, mem_en, mem_we, mem_addr, mem_wdata, fetch_rdata);
    end
    nxt;
  endtask

  task automatic test_fetch;
    rst = 1'b0; ld_req = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h8;
    mid;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h8 || freeze !== 1'b1) begin
      failures++;
      $display("FAIL fetch_grant: en=%b we=%b addr=%h frz=%b want 1 0 00000008 1",
               mem_en, mem_we, mem_addr, freeze);
    end
    nxt; mid;
    checks++;
    if (mem_en !== 1'b0 || fetch_rvalid !== 1'b0 || freeze !== 1'b1) begin
      failures++;
      $display("FAIL fetch_wait: en=%b rv=%b frz=%b want 0 0 1", mem_en, fetch_rvalid, freeze);
    end
    nxt; mid;
    checks++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hC0DE0008 || freeze !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done: rv=%b rd=%h frz=%b want 1 c0de0008 0",
               fetch_rvalid, fetch_rdata, freeze);
    end
    nxt; fetch_req = 1'b0; mid;
    checks++;
    if (mem_en !== 1'b0 || fetch_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_idle: en=%b rv=%b want 0 0", mem_en, fetch_rvalid);
    end
    nxt;
  endtask

  task automatic test_load;
    ld_req = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEADBEEF;
    mid;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_grant: en=%b we=%b addr=%h wd=%h want 1 1 00000010 deadbeef",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    nxt; mid;
    checks++;
    if (ld_done !== 1'b0 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL load_wait: done=%b en=%b want 0 0", ld_done, mem_en);
    end
    nxt; mid;
    checks++;
    if (ld_done !== 1'b1) begin
      failures++;
      $display("FAIL load_done: done=%b want 1", ld_done);
    end
    nxt; ld_req = 1'b0; mid;
    checks++;
    if (ld_done !== 1'b0 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL load_idle: done=%b en=%b want 0 0", ld_done, mem_en);
    end
    nxt;
  endtask

  task automatic test_arbitration;
    logic [9:0] seq;
    int         n;
    int         rv;
    seq = '0; n = 0; rv = 0;
    fetch_req = 1'b1; fetch_addr = 32'h30;
    ld_req = 1'b1; ld_addr = 32'h50; ld_wdata = 32'h5;
    for (int cyc = 0; cyc < 40 && n < 10; cyc++) begin
      mid;
      if (fetch_rvalid === 1'b1) rv++;
      if (mem_en === 1'b1) begin
        seq[9-n] = mem_we;
        n++;
      end
      nxt;
    end
    fetch_req = 1'b0; ld_req = 1'b0;
    checks++;
    if (n != 10 || seq !== 10'b1111011110) begin
      failures++;
      $display("FAIL arb_pattern: grants=%0d we_seq=%b want 10 1111011110", n, seq);
    end
    checks++;
    if (rv != 1) begin
      failures++;
      $display("FAIL arb_rvalid: count=%0d want 1", rv);
    end
    nxt; nxt; nxt;
  endtask

  task automatic test_flush;
    fetch_req = 1'b1; fetch_addr = 32'h20;
    mid;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h20) begin
      failures++;
      $display("FAIL flush_grant1: en=%b addr=%h want 1 00000020", mem_en, mem_addr);
    end
    nxt; fetch_flush = 1'b1;
    nxt; fetch_flush = 1'b0; mid;
    checks++;
    if (fetch_rvalid !== 1'b0 || freeze !== 1'b1) begin
      failures++;
      $display("FAIL flush_early: rv=%b frz=%b want 0 1", fetch_rvalid, freeze);
    end
    nxt; mid;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL flush_regrant1: en=%b we=%b want 1 0", mem_en, mem_we);
    end
    nxt;
    nxt; fetch_flush = 1'b1; mid;
    checks++;
    if (fetch_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL flush_late: rv=%b want 0", fetch_rvalid);
    end
    nxt; mid;
    checks++;
    if (mem_en !== 1'b1) begin
      failures++;
      $display("FAIL flush_regrant2: en=%b want 1", mem_en);
    end
    nxt; fetch_flush = 1'b0;
    nxt; mid;
    checks++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hC0DE0020) begin
      failures++;
      $display("FAIL flush_recover: rv=%b rd=%h want 1 c0de0020", fetch_rvalid, fetch_rdata);
    end
    nxt; fetch_req = 1'b0;
    nxt;
  endtask

  task automatic test_reset_mid;
    ld_req = 1'b1; ld_addr = 32'h40; ld_wdata = 32'h12345678;
    mid;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_grant: en=%b we=%b want 1 1", mem_en, mem_we);
    end
    nxt; rst = 1'b1; mid;
    checks++;
    if ({fetch_rvalid, ld_done, mem_en, mem_we} !== 4'b0000 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || fetch_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_outputs: rv=%b done=%b en=%b we=%b addr=%h wd=%h want all 0",
               fetch_rvalid, ld_done, mem_en, mem_we, mem_addr, mem_wdata);
    end
    nxt; rst = 1'b0; ld_req = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h44; mid;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h44 || ld_done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_regrant: en=%b we=%b addr=%h done=%b want 1 0 00000044 0",
               mem_en, mem_we, mem_addr, ld_done);
    end
    nxt; mid;
    checks++;
    if (ld_done !== 1'b0 || fetch_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_wait: done=%b rv=%b want 0 0", ld_done, fetch_rvalid);
    end
    nxt; mid;
    checks++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hC0DE0044 || ld_done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_fetch: rv=%b rd=%h done=%b want 1 c0de0044 0",
               fetch_rvalid, fetch_rdata, ld_done);
    end
    nxt; fetch_req = 1'b0;
    nxt;
  endtask

  task automatic test_unaligned;
    fetch_req = 1'b1; fetch_addr = 32'h0000000B;
    mid;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h8) begin
      failures++;
      $display("FAIL unal_fetch_addr: en=%b addr=%h want 1 00000008", mem_en, mem_addr);
    end
    nxt; nxt; mid;
    checks++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hC0DE0008) begin
      failures++;
      $display("FAIL unal_fetch_data: rv=%b rd=%h want 1 c0de0008", fetch_rvalid, fetch_rdata);
    end
    nxt; fetch_req = 1'b0; ld_req = 1'b1; ld_addr = 32'h13; ld_wdata = 32'hA5A5A5A5; mid;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10) begin
      failures++;
      $display("FAIL unal_load_addr: en=%b we=%b addr=%h want 1 1 00000010", mem_en, mem_we, mem_addr);
    end
    nxt; nxt; mid;
    checks++;
    if (ld_done !== 1'b1) begin
      failures++;
      $display("FAIL unal_load_done: done=%b want 1", ld_done);
    end
    nxt; ld_req = 1'b0;
    nxt;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_fetch;
    test_load;
    test_arbitration;
    test_flush;
    test_reset_mid;
    test_unaligned;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
